// File: rtl/render_pkg.sv
// Shared types and width constants for the shape renderer (widths mirror math/constants.h).
// Optional circle support is selected by RENDER_SHAPE_CIRCLE_EN in the slot datapath.
package render_pkg;

  localparam int INT_BITS        = 16;
  localparam int FLOAT_BITS      = 16;
  localparam int FLOAT_DCM_BITS  = 8;
  localparam int INT_DOUBLE_BITS = 2 * INT_BITS;
  localparam int RENDER_LATENCY  = 3;

  typedef enum logic [INT_BITS-1:0] {
    SHAPE_TRIANGLE      = INT_BITS'(0),
    SHAPE_SQUARE        = INT_BITS'(1),
    SHAPE_CIRCLE        = INT_BITS'(2),
    SHAPE_PARALLELOGRAM = INT_BITS'(3)
  } shape_ty_e;

  typedef struct packed {
    logic                         en;
    logic        [INT_BITS-1:0]   ty;
    logic signed [INT_BITS-1:0]   x0;
    logic signed [INT_BITS-1:0]   y0;
    logic        [INT_BITS-1:0]   size;
    logic signed [FLOAT_BITS-1:0] sin;
    logic signed [FLOAT_BITS-1:0] cos;
  } shape_cfg_t;

endpackage

// File: rtl/render_shape_slot.sv
// Per-slot hit datapath: S1 offsets/products, S2 rotated coords/squares, combinational S3 compare.
// RENDER_SHAPE_CIRCLE_EN adds the S2 square multipliers; without it type 2 never hits.
module render_shape_slot
  import render_pkg::*;
(
  input  logic                       clk,
  input  logic                       adv,
  input  logic signed [INT_BITS-1:0] in_x,
  input  logic signed [INT_BITS-1:0] in_y,
  input  shape_cfg_t                 cfg,
  output logic                       hit
);

  localparam int PROD_W = INT_BITS + FLOAT_BITS;
  localparam int ACC_W  = INT_DOUBLE_BITS + FLOAT_BITS;
  localparam int SUM_W  = INT_BITS + 1;
  localparam int CMP_W  = INT_BITS + 2;

  logic signed [INT_BITS-1:0] dx_d, dx_q, dy_d, dy_q;
  logic signed [PROD_W-1:0]   pxc_d, pxc_q, pys_d, pys_q, pyc_d, pyc_q, pxs_d, pxs_q;
  logic        [INT_BITS-1:0] ty1_d, ty1_q, size1_d, size1_q;
  logic                       en1_d, en1_q;

  logic signed [ACC_W-1:0]    rx, ry;
  logic signed [INT_BITS-1:0] ox_d, ox_q, oy_d, oy_q;
  logic signed [SUM_W-1:0]    sum_d, sum_q;
  logic        [INT_BITS-1:0] ty2_d, ty2_q, size2_d, size2_q;
  logic                       en2_d, en2_q;
`ifdef RENDER_SHAPE_CIRCLE_EN
  logic [INT_DOUBLE_BITS-1:0] sqx_d, sqx_q, sqy_d, sqy_q;
`endif

  logic signed [CMP_W-1:0] ox_e, oy_e, sum_e, sz_e;
  logic                    ox_in, oy_in, sum_in;

  always_comb begin
    dx_d    = in_x - cfg.x0;
    dy_d    = in_y - cfg.y0;
    pxc_d   = PROD_W'(dx_d) * PROD_W'(cfg.cos);
    pys_d   = PROD_W'(dy_d) * PROD_W'(cfg.sin);
    pyc_d   = PROD_W'(dy_d) * PROD_W'(cfg.cos);
    pxs_d   = PROD_W'(dx_d) * PROD_W'(cfg.sin);
    ty1_d   = cfg.ty;
    size1_d = cfg.size;
    en1_d   = cfg.en;
  end

  always_comb begin
    rx      = ACC_W'(pxc_q) + ACC_W'(pys_q);
    ry      = ACC_W'(pyc_q) - ACC_W'(pxs_q);
    ox_d    = INT_BITS'(rx >>> FLOAT_DCM_BITS);
    oy_d    = INT_BITS'(ry >>> FLOAT_DCM_BITS);
    sum_d   = SUM_W'(ox_d) + SUM_W'(oy_d);
    ty2_d   = ty1_q;
    size2_d = size1_q;
    en2_d   = en1_q;
`ifdef RENDER_SHAPE_CIRCLE_EN
    sqx_d   = INT_DOUBLE_BITS'(ox_d) * INT_DOUBLE_BITS'(ox_d);
    sqy_d   = INT_DOUBLE_BITS'(oy_d) * INT_DOUBLE_BITS'(oy_d);
`endif
  end

  // Compares run one bit wider than the sum so size stays non-negative.
  always_comb begin
    ox_e   = CMP_W'(ox_q);
    oy_e   = CMP_W'(oy_q);
    sum_e  = CMP_W'(sum_q);
    sz_e   = $signed({2'b00, size2_q});
    ox_in  = !ox_q[INT_BITS-1] && (ox_e < sz_e);
    oy_in  = !oy_q[INT_BITS-1] && (oy_e < sz_e);
    sum_in = !sum_q[SUM_W-1] && (sum_e < sz_e);
    hit    = 1'b0;
    if (en2_q && (size2_q != '0)) begin
      case (ty2_q)
        SHAPE_TRIANGLE:      hit = !ox_q[INT_BITS-1] && !oy_q[INT_BITS-1] && (sum_e < sz_e);
        SHAPE_SQUARE:        hit = ox_in && oy_in;
`ifdef RENDER_SHAPE_CIRCLE_EN
        SHAPE_CIRCLE:        hit = (sqx_q + sqy_q) <
                                   (INT_DOUBLE_BITS'(size2_q) * INT_DOUBLE_BITS'(size2_q));
`else
        SHAPE_CIRCLE:        hit = 1'b0;
`endif
        SHAPE_PARALLELOGRAM: hit = oy_in && sum_in;
        default:             hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      pxc_q   <= pxc_d;
      pys_q   <= pys_d;
      pyc_q   <= pyc_d;
      pxs_q   <= pxs_d;
      ty1_q   <= ty1_d;
      size1_q <= size1_d;
      en1_q   <= en1_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      sum_q   <= sum_d;
      ty2_q   <= ty2_d;
      size2_q <= size2_d;
      en2_q   <= en2_d;
`ifdef RENDER_SHAPE_CIRCLE_EN
      sqx_q   <= sqx_d;
      sqy_q   <= sqy_d;
`endif
    end
  end

endmodule

// File: rtl/render_shape_array.sv
// Shape table, stall-as-one-unit handshake and top-most-hit priority encoder over N_SHAPES slots.
// Circle support follows RENDER_SHAPE_CIRCLE_EN (see render_shape_slot).
module render_shape_array
  import render_pkg::*;
#(
  parameter int N_SHAPES = 4,
  parameter int IDX_W    = (N_SHAPES > 1) ? $clog2(N_SHAPES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [IDX_W-1:0]             cfg_idx,
  input  logic                         cfg_en,
  input  logic [INT_BITS-1:0]          cfg_ty,
  input  logic signed [INT_BITS-1:0]   cfg_x0,
  input  logic signed [INT_BITS-1:0]   cfg_y0,
  input  logic [INT_BITS-1:0]          cfg_size,
  input  logic signed [FLOAT_BITS-1:0] cfg_sin,
  input  logic signed [FLOAT_BITS-1:0] cfg_cos,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [INT_BITS-1:0]   in_x,
  input  logic signed [INT_BITS-1:0]   in_y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [INT_BITS-1:0]   out_x,
  output logic signed [INT_BITS-1:0]   out_y,
  output logic [N_SHAPES-1:0]          out_mask,
  output logic                         out_hit,
  output logic [IDX_W-1:0]             out_idx
);

  shape_cfg_t tbl_d [N_SHAPES];
  shape_cfg_t tbl_q [N_SHAPES];

  logic                       adv;
  logic [N_SHAPES-1:0]        hits, hits_v;
  logic                       v1_d, v1_q, v2_d, v2_q, ov_d, ov_q;
  logic signed [INT_BITS-1:0] x1_d, x1_q, y1_d, y1_q, x2_d, x2_q, y2_d, y2_q;
  logic signed [INT_BITS-1:0] ox_d, ox_q, oy_d, oy_q;
  logic [N_SHAPES-1:0]        mask_d, mask_q;
  logic                       hit_d, hit_q, found;
  logic [IDX_W-1:0]           idx_d, idx_q, pidx;

  assign adv       = !ov_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = ov_q;
  assign out_x     = ox_q;
  assign out_y     = oy_q;
  assign out_mask  = mask_q;
  assign out_hit   = hit_q;
  assign out_idx   = idx_q;

  // Out-of-range indices simply match no slot.
  always_comb begin
    tbl_d = tbl_q;
    for (int unsigned i = 0; i < N_SHAPES; i++) begin
      if (cfg_we && (cfg_idx == IDX_W'(i))) begin
        tbl_d[i] = '{en: cfg_en, ty: cfg_ty, x0: cfg_x0, y0: cfg_y0,
                     size: cfg_size, sin: cfg_sin, cos: cfg_cos};
      end
    end
  end

  for (genvar g = 0; g < N_SHAPES; g++) begin : g_slot
    render_shape_slot u_slot (
      .clk  (clk),
      .adv  (adv),
      .in_x (in_x),
      .in_y (in_y),
      .cfg  (tbl_q[g]),
      .hit  (hits[g])
    );
  end

  always_comb begin
    hits_v = v2_q ? hits : '0;
    found  = 1'b0;
    pidx   = '0;
    for (int unsigned i = 0; i < N_SHAPES; i++) begin
      if (hits_v[i] && !found) begin
        found = 1'b1;
        pidx  = IDX_W'(i);
      end
    end
  end

  always_comb begin
    v1_d   = v1_q;
    v2_d   = v2_q;
    ov_d   = ov_q;
    x1_d   = x1_q;
    y1_d   = y1_q;
    x2_d   = x2_q;
    y2_d   = y2_q;
    ox_d   = ox_q;
    oy_d   = oy_q;
    mask_d = mask_q;
    hit_d  = hit_q;
    idx_d  = idx_q;
    if (adv) begin
      v1_d   = in_valid;
      x1_d   = in_x;
      y1_d   = in_y;
      v2_d   = v1_q;
      x2_d   = x1_q;
      y2_d   = y1_q;
      ov_d   = v2_q;
      ox_d   = v2_q ? x2_q : '0;
      oy_d   = v2_q ? y2_q : '0;
      mask_d = hits_v;
      hit_d  = found;
      idx_d  = pidx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_SHAPES; i++) tbl_q[i].en <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      ov_q   <= 1'b0;
      x1_q   <= '0;
      y1_q   <= '0;
      x2_q   <= '0;
      y2_q   <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
      mask_q <= '0;
      hit_q  <= 1'b0;
      idx_q  <= '0;
    end else begin
      tbl_q  <= tbl_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      ov_q   <= ov_d;
      x1_q   <= x1_d;
      y1_q   <= y1_d;
      x2_q   <= x2_d;
      y2_q   <= y2_d;
      ox_q   <= ox_d;
      oy_q   <= oy_d;
      mask_q <= mask_d;
      hit_q  <= hit_d;
      idx_q  <= idx_d;
    end
  end

endmodule
